accum_bram: RTL and testbench

- Parametrised accumulator RAM for the Hough vote array: one read port plus an atomic read-modify-write increment port.
- Built-in clear engine zeroes the whole array between frames.
- Sits between the vote generator (increment port) and the peak finder (read port).
- Uses synchronous-read memory for block-RAM inference. Internal forwarding gives exact sequential increment semantics.

---
 rtl/accum_bram_if.sv | 29 ++
 rtl/accum_bram.sv | 238 +++++++++++++++++++++++
 tb/tb_accum_bram.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_bram_if.sv
// Client-side bus of the accumulator RAM: clear request, increment port and
// read port. The vote generator / peak finder side uses the master modport,
// the accumulator itself uses the slave modport.
interface accum_bram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 12,
    parameter int INC_WIDTH  = 4
);
    logic                  clear_start;
    logic                  busy;
    logic                  inc_valid;
    logic [ADDR_W-1:0]     inc_addr;
    logic [INC_WIDTH-1:0]  inc_amount;
    logic                  inc_ready;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output clear_start, inc_valid, inc_addr, inc_amount, rd_en, rd_addr,
        input  busy, inc_ready, rd_valid, rd_data
    );

    modport slave (
        input  clear_start, inc_valid, inc_addr, inc_amount, rd_en, rd_addr,
        output busy, inc_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/accum_bram.sv
// Hough vote accumulator RAM: synchronous-read word array with a pipelined
// read-modify-write increment port (forwarded so that back-to-back hits on
// one word accumulate exactly), a 2-cycle read port and a clear engine that
// drains in-flight traffic and then zeroes every word, one per cycle.

// Simulation-only legality checks on accepted addresses.
module accum_bram_chk #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
)(
    input logic              clock,
    input logic              reset,
    input logic              inc_fire_i,
    input logic [ADDR_W-1:0] inc_addr_i,
    input logic              rd_fire_i,
    input logic [ADDR_W-1:0] rd_addr_i
);
    localparam int            ADDR_W1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = ADDR_W1'(DEPTH);

    a_inc_addr_range: assert property (@(posedge clock) disable iff (!reset)
        inc_fire_i |-> ({1'b0, inc_addr_i} < DEPTH_L));

    a_rd_addr_range: assert property (@(posedge clock) disable iff (!reset)
        rd_fire_i |-> ({1'b0, rd_addr_i} < DEPTH_L));
endmodule

module accum_bram #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 4096,
    parameter int INC_WIDTH      = 4,
    parameter int SATURATE       = 1,
    parameter int CLEAR_ON_RESET = 1
)(
    input logic         clock,
    input logic         reset,
    accum_bram_if.slave bus
);
    localparam int              ADDR_W     = $clog2(DEPTH);
    localparam int              ADDR_W1    = ADDR_W + 1;
    localparam int              PAD_W      = DATA_WIDTH + 1 - INC_WIDTH;
    localparam logic [ADDR_W:0] DEPTH_L    = ADDR_W1'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic       BUSY_RESET = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;

    // True when an address refers to an existing word.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                  busy_q, busy_d;

    logic                  s1_valid_q;
    logic [ADDR_W-1:0]     s1_addr_q;
    logic [INC_WIDTH-1:0]  s1_amt_q;
    logic                  s2_valid_q;
    logic [ADDR_W-1:0]     s2_addr_q;
    logic [INC_WIDTH-1:0]  s2_amt_q;
    logic [DATA_WIDTH-1:0] s2_word_q;

    logic                  r1_valid_q;
    logic [ADDR_W-1:0]     r1_addr_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  inc_fire_s;
    logic                  rd_fire_s;
    logic                  drain_done_s;
    logic                  fwd_s;
    logic [DATA_WIDTH:0]   sum_ext_s;
    logic [DATA_WIDTH-1:0] sum_s;
    logic                  mem_we_s;
    logic [ADDR_W-1:0]     mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    assign inc_fire_s = bus.inc_valid & ~busy_q;
    assign rd_fire_s  = bus.rd_en & ~busy_q;

    // The only S2 write that can still be in flight when DRAIN exits lands
    // on the exit edge itself, so the first clear write never collides.
    assign drain_done_s = ~s1_valid_q & ~r1_valid_q;

    // S2 is loading the word that the S3 write updates on this same edge:
    // take the fresh sum instead of the stale memory output.
    assign fwd_s = s2_valid_q & (s2_addr_q == s1_addr_q);

    assign bus.busy      = busy_q;
    assign bus.inc_ready = ~busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

    // S3 adder with optional saturation on carry-out.
    always_comb begin
        sum_ext_s = {1'b0, s2_word_q} + {{PAD_W{1'b0}}, s2_amt_q};
        if ((SATURATE != 0) && sum_ext_s[DATA_WIDTH]) begin
            sum_s = {DATA_WIDTH{1'b1}};
        end else begin
            sum_s = sum_ext_s[DATA_WIDTH-1:0];
        end
    end

    // Single memory write port shared by the clear engine and the S3 write.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = s2_addr_q;
        mem_wdata_s = sum_s;
        if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
        end else if (s2_valid_q && addr_ok(s2_addr_q)) begin
            mem_we_s    = 1'b1;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Clear FSM next-state: IDLE -> DRAIN -> CLEAR (DEPTH cycles) -> IDLE.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end else begin
                    state_d   = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Clear FSM state, clear counter and registered busy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= {ADDR_W{1'b0}};
            busy_q    <= BUSY_RESET;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Increment pipeline S1 (request capture) and S2 (word fetch + forward).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= {ADDR_W{1'b0}};
            s1_amt_q   <= {INC_WIDTH{1'b0}};
            s2_valid_q <= 1'b0;
            s2_addr_q  <= {ADDR_W{1'b0}};
            s2_amt_q   <= {INC_WIDTH{1'b0}};
            s2_word_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_valid_q <= inc_fire_s;
            s1_addr_q  <= bus.inc_addr;
            s1_amt_q   <= bus.inc_amount;
            s2_valid_q <= s1_valid_q;
            s2_addr_q  <= s1_addr_q;
            s2_amt_q   <= s1_amt_q;
            if (fwd_s) begin
                s2_word_q <= sum_s;
            end else begin
                s2_word_q <= mem_q[s1_addr_q];
            end
        end
    end

    // Read port: address capture, then synchronous memory read into rd_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r1_valid_q <= 1'b0;
            r1_addr_q  <= {ADDR_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            r1_valid_q <= rd_fire_s;
            r1_addr_q  <= bus.rd_addr;
            rd_valid_q <= r1_valid_q;
            if (r1_valid_q) begin
                rd_data_q <= mem_q[r1_addr_q];
            end else begin
                rd_data_q <= rd_data_q;
            end
        end
    end

    // Memory array write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    accum_bram_chk #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_chk (
        .clock      (clock),
        .reset      (reset),
        .inc_fire_i (inc_fire_s),
        .inc_addr_i (bus.inc_addr),
        .rd_fire_i  (rd_fire_s),
        .rd_addr_i  (bus.rd_addr)
    );
endmodule

// File: tb/tb_accum_bram.sv
// Directed bench for accum_bram: two instances (saturating and wrapping,
// 8-bit words, 16 entries, clear-on-reset) driven with identical stimulus.
module tb_accum_bram;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int IW = 4;

    logic          clk;
    logic          rst_n;
    logic          clear_start;
    logic          inc_valid;
    logic [AW-1:0] inc_addr;
    logic [IW-1:0] inc_amount;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    int n_total;
    int n_bad;

    accum_bram_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .INC_WIDTH(IW)) if_s ();
    accum_bram_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .INC_WIDTH(IW)) if_w ();

    assign if_s.clear_start = clear_start;
    assign if_s.inc_valid   = inc_valid;
    assign if_s.inc_addr    = inc_addr;
    assign if_s.inc_amount  = inc_amount;
    assign if_s.rd_en       = rd_en;
    assign if_s.rd_addr     = rd_addr;
    assign if_w.clear_start = clear_start;
    assign if_w.inc_valid   = inc_valid;
    assign if_w.inc_addr    = inc_addr;
    assign if_w.inc_amount  = inc_amount;
    assign if_w.rd_en       = rd_en;
    assign if_w.rd_addr     = rd_addr;

    accum_bram #(
        .DATA_WIDTH(DW), .DEPTH(16), .INC_WIDTH(IW), .SATURATE(1), .CLEAR_ON_RESET(1)
    ) u_sat (
        .clock (clk),
        .reset (rst_n),
        .bus   (if_s)
    );

    accum_bram #(
        .DATA_WIDTH(DW), .DEPTH(16), .INC_WIDTH(IW), .SATURATE(0), .CLEAR_ON_RESET(1)
    ) u_wrap (
        .clock (clk),
        .reset (rst_n),
        .bus   (if_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read and return both instances' data after the 2-cycle latency.
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] ds, output logic [DW-1:0] dw);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        tick();
        check_val("rd_valid", {31'd0, if_s.rd_valid}, 32'd1);
        ds = if_s.rd_data;
        dw = if_w.rd_data;
    endtask

    task automatic do_inc(input logic [AW-1:0] a, input logic [IW-1:0] amt);
        inc_valid  = 1'b1;
        inc_addr   = a;
        inc_amount = amt;
        tick();
        inc_valid  = 1'b0;
    endtask

    // Count cycles with busy high (bounded) and how many of them had inc_ready high.
    task automatic count_busy(output int n, output int ready_hi);
        n = 0;
        ready_hi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!if_s.busy) break;
            n++;
            if (if_s.inc_ready) ready_hi++;
        end
        tick();
    endtask

    initial begin
        logic [DW-1:0] ds;
        logic [DW-1:0] dw;
        int nb;
        int nr;

        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        clear_start = 1'b0;
        inc_valid   = 1'b0;
        inc_addr    = '0;
        inc_amount  = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;

        repeat (3) tick();
        check_val("rst_busy", {31'd0, if_s.busy}, 32'd1);
        check_val("rst_rd_valid", {31'd0, if_s.rd_valid}, 32'd0);
        check_val("rst_rd_data", {24'd0, if_s.rd_data}, 32'd0);

        // Clear on reset release: exactly DEPTH busy cycles, inc_ready low.
        rst_n = 1'b1;
        count_busy(nb, nr);
        check_val("init_busy_cycles", nb, 32'd16);
        check_val("init_ready_while_busy", nr, 32'd0);
        for (int a = 0; a < 16; a++) begin
            do_read(AW'(a), ds, dw);
            check_val("init_zero", {24'd0, ds}, 32'd0);
        end

        // Five back-to-back increments to one word; read two cycles later.
        for (int k = 0; k < 5; k++) begin
            inc_valid  = 1'b1;
            inc_addr   = 4'd3;
            inc_amount = 4'd1;
            tick();
        end
        inc_valid = 1'b0;
        tick();
        do_read(4'd3, ds, dw);
        check_val("b2b_addr3", {24'd0, ds}, 32'd5);

        // Fresh array, then interleaved 3,4,3,4 with amounts 2,3,2,3.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        count_busy(nb, nr);
        check_val("clear_idle_busy", nb, 32'd17);
        for (int k = 0; k < 4; k++) begin
            inc_valid  = 1'b1;
            inc_addr   = (k % 2 == 0) ? 4'd3 : 4'd4;
            inc_amount = (k % 2 == 0) ? 4'd2 : 4'd3;
            tick();
        end
        inc_valid = 1'b0;
        tick();
        do_read(4'd3, ds, dw);
        check_val("ilv_addr3", {24'd0, ds}, 32'd4);
        do_read(4'd4, ds, dw);
        check_val("ilv_addr4", {24'd0, ds}, 32'd6);

        // Visibility: addr 9 = 10, +1 at edge c, reads accepted at c+1 and c+2.
        do_inc(4'd9, 4'd10);
        repeat (2) tick();
        inc_valid  = 1'b1;
        inc_addr   = 4'd9;
        inc_amount = 4'd1;
        tick();
        inc_valid  = 1'b0;
        rd_en      = 1'b1;
        rd_addr    = 4'd9;
        tick();
        check_val("vis_lat1_valid", {31'd0, if_s.rd_valid}, 32'd0);
        tick();
        rd_en = 1'b0;
        check_val("vis_old_valid", {31'd0, if_s.rd_valid}, 32'd1);
        check_val("vis_old_data", {24'd0, if_s.rd_data}, 32'd10);
        tick();
        check_val("vis_new_valid", {31'd0, if_s.rd_valid}, 32'd1);
        check_val("vis_new_data", {24'd0, if_s.rd_data}, 32'd11);
        tick();
        check_val("vis_idle_valid", {31'd0, if_s.rd_valid}, 32'd0);
        check_val("vis_hold_data", {24'd0, if_s.rd_data}, 32'd11);

        // Saturation versus wrap: 300 increments of 1 on addr 7.
        for (int k = 0; k < 300; k++) begin
            inc_valid  = 1'b1;
            inc_addr   = 4'd7;
            inc_amount = 4'd1;
            tick();
        end
        inc_valid = 1'b0;
        tick();
        do_read(4'd7, ds, dw);
        check_val("sat_addr7", {24'd0, ds}, 32'd255);
        check_val("wrap_addr7", {24'd0, dw}, 32'd44);

        // Clear with two increments in flight plus one in the clear_start cycle.
        do_inc(4'd2, 4'd5);
        inc_valid  = 1'b1;
        inc_addr   = 4'd2;
        inc_amount = 4'd5;
        tick();
        clear_start = 1'b1;
        check_val("clr_ready_same_cycle", {31'd0, if_s.inc_ready}, 32'd1);
        tick();
        clear_start = 1'b0;
        inc_valid   = 1'b0;
        check_val("clr_busy_rise", {31'd0, if_s.busy}, 32'd1);
        count_busy(nb, nr);
        check_val("clr_busy_cycles", nb, 32'd18);
        do_read(4'd2, ds, dw);
        check_val("clr_addr2", {24'd0, ds}, 32'd0);
        do_read(4'd9, ds, dw);
        check_val("clr_addr9", {24'd0, ds}, 32'd0);

        // Reset mid-clear: asynchronous return to reset state, then a full clear.
        do_inc(4'd9, 4'd11);
        repeat (2) tick();
        do_read(4'd9, ds, dw);
        check_val("pre_rst_addr9", {24'd0, ds}, 32'd11);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", {31'd0, if_s.busy}, 32'd1);
        check_val("mid_rst_ready", {31'd0, if_s.inc_ready}, 32'd0);
        check_val("mid_rst_rd_valid", {31'd0, if_s.rd_valid}, 32'd0);
        check_val("mid_rst_rd_data", {24'd0, if_s.rd_data}, 32'd0);
        check_val("mid_rst_rd_data_w", {24'd0, if_w.rd_data}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        count_busy(nb, nr);
        check_val("rerst_busy_cycles", nb, 32'd16);
        do_read(4'd9, ds, dw);
        check_val("rerst_addr9", {24'd0, ds}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
